// File: rtl/modulo_n_seq.sv
// modulo_n_seq: bit-serial restoring divider, value_in mod/div MOD.
// One dividend bit per clock, MSB first, start/ready/done handshake.
module modulo_n_seq #(
  parameter int WIDTH = 8,
  parameter int MOD = 6,
  localparam int RW = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value_in,
  output logic             ready,
  output logic             done,
  output logic [RW-1:0]    mod_out,
  output logic [WIDTH-1:0] quot_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [RW:0] MOD_R = (RW+1)'(MOD);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] quot;
  logic [RW:0]      rem;
  logic [CW-1:0]    cnt;

  logic [RW:0]      trial;
  logic             fits;
  logic [RW:0]      rem_next;
  logic [WIDTH-1:0] quot_next;

  // rem < MOD, so shifting it left by one cannot lose a set bit
  always_comb begin
    trial = (rem << 1) | {{RW{1'b0}}, dividend[WIDTH-1]};
    fits = (trial >= MOD_R);
    rem_next = fits ? (trial - MOD_R) : trial;
    quot_next = (quot << 1) | {{(WIDTH-1){1'b0}}, fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done <= 1'b0;
      mod_out <= '0;
      quot_out <= '0;
      dividend <= '0;
      quot <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dividend <= value_in;
            quot <= '0;
            rem <= '0;
            cnt <= CW'(WIDTH-1);
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          rem <= rem_next;
          quot <= quot_next;
          dividend <= dividend << 1;
          if (cnt == '0) begin
            mod_out <= rem_next[RW-1:0];
            quot_out <= quot_next;
            done <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/modulo_n_seq.md
Name: modulo_n_seq

Overview:
- Bit-serial modulo-N / divide-by-N unit: takes a WIDTH-bit unsigned value and produces value mod MOD and value / MOD.
- Uses restoring long division, MSB first, one bit per clock.
- Generalises the fixed 3-bit mod-6 combinational reducer to arbitrary width and modulus, with a start/ready/done handshake.
- Instantiated wherever counters or addresses must be reduced by a non-power-of-2 modulus without a wide combinational divider.

Parameters:
WIDTH, 8, width of value_in and quot_out; legal range 2..32
MOD, 6, modulus; legal range 2..2^WIDTH-1; RW = $clog2(MOD) is a derived localparam giving the mod_out width

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only when ready=1
value_in  input  WIDTH  unsigned dividend; captured in the cycle start is accepted
ready  output  1  high when idle and able to accept start
done  output  1  single-cycle pulse; results valid in this cycle
mod_out  output  RW  value_in mod MOD
quot_out  output  WIDTH  value_in / MOD (integer)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset state: state=IDLE, ready=1, done=0, mod_out=0, quot_out=0, internal remainder=0, bit counter=0.
- rst overrides all other inputs in the same edge, including mid-operation. An aborted operation produces no done pulse, and the outputs return to 0.
- States:
  - IDLE: ready=1. On an edge with start=1: latch value_in into the shift register, clear the remainder (width RW+1), set counter=WIDTH-1, go to RUN.
  - RUN: ready=0. On each edge, take the MSB of the shift register:
    - r' = {rem, msb}
    - if r' >= MOD: rem = r' - MOD and shift 1 into the quotient; else rem = r' and shift 0 into the quotient.
    - Shift the dividend left. When counter==0 (WIDTH bits processed), go to DONE; otherwise decrement counter.
  - DONE: ready=0, done=1 for exactly this one cycle. mod_out and quot_out are registered on entry, so they are valid in this cycle. Next edge goes to IDLE unconditionally.
- Latency:
  - start accepted at edge k → done high in the cycle following edge k+WIDTH.
  - ready is low from edge k through the DONE cycle and high again after edge k+WIDTH+1.
  - Minimum issue interval is WIDTH+2 cycles.
- start while ready=0 (RUN or DONE) is ignored. No queuing, no effect on the operation in flight.
- start held permanently high starts a new operation on the first IDLE edge after each DONE.
- mod_out and quot_out hold their last result until the next DONE or rst. They do not change during RUN.
- value_in is don't-care except on the accepting edge. Changing it during RUN does not affect the result.
- Arithmetic width rules:
  - The remainder register is RW+1 bits so that 2*(MOD-1)+1 fits.
  - The comparison and subtraction are done at RW+1 bits; mod_out is the low RW bits, which is always < MOD.
- Boundary cases:
  - value_in < MOD gives quot=0 and mod=value_in.
  - value_in=0 gives 0,0.
  - MOD a power of 2 must still give correct results; no special path.
  - value_in = 2^WIDTH-1 must not overflow the quotient.

Test Plan:
- WIDTH=8, MOD=6, value_in=200, start pulse at edge k → done high exactly in the cycle after edge k+8; mod_out=2, quot_out=33; ready=1 again the following cycle.
- WIDTH=8, MOD=6, exhaustive 0..255 → each result matches v%6 and v/6. Also check 255 → mod 3, quot 42, and 5 → mod 5, quot 0.
- WIDTH=3, MOD=6, exhaustive 0..7 → mod_out = 0,1,2,3,4,5,0,1; quot_out=1 for 6 and 7, 0 otherwise.
- Operation on 200 in flight, with start pulsed with value_in=17 during RUN and again during DONE → both ignored; result remains 2/33; a single done pulse.
- rst asserted 4 cycles into an operation on 200 → next cycle ready=1, done=0, mod_out=0, quot_out=0, no later done. A following start with 100 gives 4/16.
- Instance WIDTH=8, MOD=8, start held high with value_in=255 → repeated done pulses every 10 cycles, each with mod_out=7 and quot_out=31.
